// File: rtl/uart_rx_buf_ctrl_if.sv
// Receive-buffer bus: receiver/consumer-facing signals of uart_rx_buf_ctrl.
// The master side drives the receiver byte stream and consumer controls,
// the slave side (the buffer controller) returns FIFO status and interrupts.
interface uart_rx_buf_ctrl_if #(
    parameter int Depth = 8
) ();
    localparam int CW = $clog2(Depth + 1);

    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          en_i;
    logic          flush_i;
    logic [CW-1:0] thresh_i;
    logic          pop_i;
    logic          clr_ovr_i;

    logic [7:0]    data_o;
    logic          valid_o;
    logic [CW-1:0] count_o;
    logic          overrun_o;
    logic          irq_thresh_o;
    logic          irq_timeout_o;

    modport master (
        output rx_data_i, rx_valid_i, en_i, flush_i, thresh_i, pop_i, clr_ovr_i,
        input  data_o, valid_o, count_o, overrun_o, irq_thresh_o, irq_timeout_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, en_i, flush_i, thresh_i, pop_i, clr_ovr_i,
        output data_o, valid_o, count_o, overrun_o, irq_thresh_o, irq_timeout_o
    );
endinterface

// File: rtl/uart_rx_buf_ctrl.sv
// UART receive buffer controller: show-ahead byte FIFO with sticky overrun,
// fill-level threshold interrupt and idle character-timeout interrupt.
module uart_rx_buf_ctrl #(
    parameter int Depth       = 8,
    parameter int BitTicks    = 16,
    parameter int TimeoutBits = 40
) (
    input  logic            clk_i,
    input  logic            arst_ni,
    uart_rx_buf_ctrl_if.slave bus
);
    localparam int AW     = $clog2(Depth);
    localparam int CW     = $clog2(Depth + 1);
    localparam int TLimit = TimeoutBits * BitTicks;
    localparam int TW     = $clog2(TLimit + 1);

    localparam logic [CW-1:0] CountFull = CW'(Depth);
    localparam logic [TW-1:0] TmoLimit  = TW'(TLimit);

    logic [7:0]    mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tmo_cnt;
    logic          overrun;

    logic empty;
    logic full;
    logic push_req;
    logic pop_acc;
    logic push_acc;

    // Handshake qualification: a pop frees a slot, so a full FIFO still takes a push
    always_comb begin
        empty    = (count == '0);
        full     = (count == CountFull);
        push_req = bus.rx_valid_i & bus.en_i & ~bus.flush_i;
        pop_acc  = bus.pop_i & ~empty & ~bus.flush_i;
        push_acc = push_req & (~full | pop_acc);
    end

    // Byte storage, written on accepted push; no reset needed since valid_o gates it
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem[wr_ptr] <= bus.rx_data_i;
        end
    end

    // Pointers and fill level; flush discards any concurrent push/pop
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Character timeout: counts idle cycles while data sits unread, saturating
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            tmo_cnt <= '0;
        end else if (bus.flush_i || push_acc || pop_acc || empty) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TmoLimit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Sticky overrun: a dropped byte wins over a same-cycle clear
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            overrun <= 1'b0;
        end else if (push_req && !push_acc) begin
            overrun <= 1'b1;
        end else if (bus.clr_ovr_i) begin
            overrun <= 1'b0;
        end
    end

    assign bus.data_o        = mem[rd_ptr];
    assign bus.valid_o       = ~empty;
    assign bus.count_o       = count;
    assign bus.overrun_o     = overrun;
    assign bus.irq_thresh_o  = (bus.thresh_i != '0) && (count >= bus.thresh_i);
    assign bus.irq_timeout_o = (tmo_cnt == TmoLimit);
endmodule

// File: doc/uart_rx_buf_ctrl.md
UART_RX_BUF_CTRL -- requirements
Module: uart_rx_buf_ctrl

Interface
REQ-001 SHALL have parameter Depth, default 8, receive FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter BitTicks, default 16, clk cycles per UART bit (matches receiver).
REQ-003 SHALL have parameter TimeoutBits, default 40, idle bit times before character timeout.
REQ-004 SHALL have port clk_i  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port arst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have port rx_data_i  in  8  byte from receiver.
REQ-007 SHALL have port rx_valid_i  in  1  one-cycle pulse, rx_data_i valid.
REQ-008 SHALL have port en_i  in  1  receive enable; 0 = ignore rx_valid_i.
REQ-009 SHALL have port flush_i  in  1  synchronous FIFO/timeout clear.
REQ-010 SHALL have port thresh_i  in  CW  fill-level threshold, CW = $clog2(Depth+1).
REQ-011 SHALL have port pop_i  in  1  consumer read strobe.
REQ-012 SHALL have port clr_ovr_i  in  1  clear sticky overrun.
REQ-013 SHALL have port data_o  out  8  show-ahead head-of-FIFO byte.
REQ-014 SHALL have port valid_o  out  1  FIFO non-empty.
REQ-015 SHALL have port count_o  out  CW  current fill level.
REQ-016 SHALL have port overrun_o  out  1  sticky: byte dropped on full.
REQ-017 SHALL have port irq_thresh_o  out  1  level: count_o >= thresh_i and thresh_i != 0.
REQ-018 SHALL have port irq_timeout_o  out  1  level: character timeout pending.

Function
REQ-019 Push SHALL occur when rx_valid_i & en_i & !flush_i & (not full or pop accepted same cycle).
REQ-020 Pop SHALL be accepted when pop_i & valid_o & !flush_i; pop_i while empty SHALL be ignored, no state change.
REQ-021 Pushed byte SHALL appear on data_o/valid_o the cycle after push when FIFO was empty (1-cycle latency).
REQ-022 data_o SHALL be memory[rd_ptr] combinationally; value when valid_o=0 is don't-care.
REQ-023 Pointers SHALL be $clog2(Depth) bits, wrap modulo Depth; count_o SHALL be +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
REQ-024 Simultaneous push+pop when full SHALL accept both; count stays Depth, no overrun.
REQ-025 Push request while full without accepted pop SHALL drop byte, leave FIFO unchanged, set overrun_o next cycle.
REQ-026 overrun_o SHALL stay set until clr_ovr_i; clr_ovr_i same cycle as new overrun SHALL leave overrun_o=1 (set wins).
REQ-027 flush_i SHALL, next cycle, zero pointers and count, clear timeout state; overrun_o unaffected; concurrent push/pop discarded.
REQ-028 irq_thresh_o SHALL be combinational from count_o and thresh_i; thresh_i > Depth SHALL never assert.
REQ-029 Timeout counter SHALL be 0 and irq_timeout_o=0 while FIFO empty, or on any accepted push, accepted pop, or flush.
REQ-030 Otherwise timeout counter SHALL increment each cycle, saturating at TimeoutBits*BitTicks; irq_timeout_o SHALL be 1 when counter equals TimeoutBits*BitTicks.
REQ-031 Timeout counter width SHALL be $clog2(TimeoutBits*BitTicks+1); no wrap.
REQ-032 en_i low SHALL not affect pop, flush, timeout counting or stored data.

Reset
REQ-033 arst_ni low SHALL asynchronously set pointers, count_o, timeout counter, overrun_o to 0; hence valid_o=0, irq_thresh_o=0, irq_timeout_o=0.
REQ-034 FIFO storage SHALL not require reset; reset mid-frame SHALL discard all content; first push after release behaves as from empty.

Verification
REQ-035 Push 0xA5, 0x3C, 0xFF (en_i=1), then pop x3 -> data_o sequence A5,3C,FF; count_o 3->0; valid_o 0 after last pop.
REQ-036 Depth=8: push 9 bytes without pop -> count_o=8, 9th dropped, overrun_o=1; clr_ovr_i -> overrun_o=0; pops return first 8 in order.
REQ-037 Full FIFO, rx_valid_i and pop_i same cycle -> count_o stays 8, overrun_o stays 0, new byte read last.
REQ-038 thresh_i=4: push 3 -> irq_thresh_o=0; 4th push -> 1 next cycle; pop -> 0; thresh_i=0 -> never asserts.
REQ-039 One byte pushed, no activity for 640 cycles (40*16) -> irq_timeout_o rises exactly at cycle 640 after push, holds; pop -> 0 next cycle and count_o=0.
REQ-040 Fill 5 bytes, assert flush_i with rx_valid_i -> count_o=0, valid_o=0, overrun_o unchanged; assert arst_ni low mid-fill -> all outputs 0 immediately.
